offset_finder_arbiter: RTL and testbench

Shares one offset_finder instance between NUM_CH photodiode decoder channels using a round-robin scheduler. Each channel presents a level request with its captured LFSR word and polynomial. The arbiter sequences the finder's enable/ready level handshake, returns the offset with a one-cycle result strobe tagged by channel, and guards against a hung search with a watchdog. It sits between the per-sensor decoders and the single offset_finder in the tracker top level.

---
 rtl/offset_finder_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/offset_finder_arbiter.sv | 159 +++++++++++++++
 tb/tb_offset_finder_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/offset_finder_pkg.sv
// Shared types and constants for the offset_finder arbiter slice.
package offset_finder_pkg;

    localparam int LFSR_W                  = 17;
    localparam int DEFAULT_WATCHDOG_CYCLES = 200000;

    typedef enum logic [2:0] {
        SYNC,
        ARB,
        START,
        FIND,
        RELEASE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_valid
);

    always_comb begin
        int              idx;
        logic [CH_W-1:0] sel;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        sel         = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            sel = CH_W'(idx);
            if (!grant_valid && req[sel]) begin
                grant_valid = 1'b1;
                grant[sel]  = 1'b1;
                grant_idx   = sel;
            end
        end
    end

endmodule

// File: rtl/offset_finder_arbiter.sv
// Time-shares one offset_finder between NUM_CH decoder channels with
// round-robin scheduling, an enable/ready handshake sequencer and a watchdog.
module offset_finder_arbiter
    import offset_finder_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int CH_W            = 2,
    parameter int WATCHDOG_CYCLES = DEFAULT_WATCHDOG_CYCLES
) (
    input  logic                     clk_96MHz,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req,
    input  logic [LFSR_W*NUM_CH-1:0] req_polynomial,
    input  logic [LFSR_W*NUM_CH-1:0] req_data,
    output logic [LFSR_W-1:0]        finder_polynomial,
    output logic [LFSR_W-1:0]        finder_data,
    output logic                     finder_enable,
    input  logic [LFSR_W-1:0]        finder_offset,
    input  logic                     finder_ready,
    output logic                     busy,
    output logic                     res_valid,
    output logic [CH_W-1:0]          res_ch,
    output logic [LFSR_W-1:0]        res_offset,
    output logic                     res_found,
    output logic                     res_timeout
);

    localparam int              WD_W    = $clog2(WATCHDOG_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_idx;
    logic [WD_W-1:0]   wd_cnt;
    logic              sync_cnt;
    logic              rel_cnt;

    logic [NUM_CH-1:0] arb_grant;
    logic [CH_W-1:0]   arb_idx;
    logic              arb_valid;
    logic [LFSR_W-1:0] sel_poly;
    logic [LFSR_W-1:0] sel_data;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr (
        .req         (req),
        .ptr         (rr_ptr),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        sel_poly = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_grant[i]) begin
                sel_poly = sel_poly | req_polynomial[LFSR_W*i +: LFSR_W];
                sel_data = sel_data | req_data[LFSR_W*i +: LFSR_W];
            end
        end
    end

    // The watchdog is checked before ready so a search ending on the
    // abort cycle is still reported as a timeout.
    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            state             <= SYNC;
            rr_ptr            <= '0;
            grant_idx         <= '0;
            wd_cnt            <= '0;
            sync_cnt          <= 1'b0;
            rel_cnt           <= 1'b0;
            finder_enable     <= 1'b0;
            finder_polynomial <= '0;
            finder_data       <= '0;
            busy              <= 1'b1;
            res_valid         <= 1'b0;
            res_ch            <= '0;
            res_offset        <= '0;
            res_found         <= 1'b0;
            res_timeout       <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                SYNC: begin
                    finder_enable <= 1'b0;
                    if (finder_ready) begin
                        if (sync_cnt) begin
                            state <= ARB;
                            busy  <= 1'b0;
                        end else begin
                            sync_cnt <= 1'b1;
                        end
                    end else begin
                        sync_cnt <= 1'b0;
                    end
                end
                ARB: begin
                    if (arb_valid) begin
                        grant_idx         <= arb_idx;
                        finder_polynomial <= sel_poly;
                        finder_data       <= sel_data;
                        finder_enable     <= 1'b1;
                        wd_cnt            <= '0;
                        busy              <= 1'b1;
                        state             <= START;
                    end
                end
                START, FIND: begin
                    if (wd_cnt == WD_LAST) begin
                        finder_enable <= 1'b0;
                        res_valid     <= 1'b1;
                        res_ch        <= grant_idx;
                        res_offset    <= '0;
                        res_found     <= 1'b0;
                        res_timeout   <= 1'b1;
                        sync_cnt      <= 1'b0;
                        state         <= SYNC;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (state == START) begin
                            if (!finder_ready) begin
                                state <= FIND;
                            end
                        end else if (finder_ready) begin
                            res_valid     <= 1'b1;
                            res_ch        <= grant_idx;
                            res_offset    <= finder_offset;
                            res_found     <= (finder_offset != '0);
                            res_timeout   <= 1'b0;
                            finder_enable <= 1'b0;
                            rel_cnt       <= 1'b0;
                            state         <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (rel_cnt) begin
                        rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
                        busy   <= 1'b0;
                        state  <= ARB;
                    end else begin
                        rel_cnt <= 1'b1;
                    end
                end
                default: begin
                    finder_enable <= 1'b0;
                    sync_cnt      <= 1'b0;
                    busy          <= 1'b1;
                    state         <= SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_offset_finder_arbiter.sv
// Bench for offset_finder_arbiter: behavioural finder model, grant/result
// scoreboards, a vector table of single searches and hand-written corner cases.
module tb_offset_finder_arbiter;
    import offset_finder_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int WD     = 100;

    logic                     clk_96MHz = 1'b0;
    logic                     reset;
    logic [NUM_CH-1:0]        req;
    logic [LFSR_W*NUM_CH-1:0] req_polynomial;
    logic [LFSR_W*NUM_CH-1:0] req_data;
    logic [LFSR_W-1:0]        finder_polynomial;
    logic [LFSR_W-1:0]        finder_data;
    logic                     finder_enable;
    logic [LFSR_W-1:0]        finder_offset = '0;
    logic                     finder_ready  = 1'b1;
    logic                     busy;
    logic                     res_valid;
    logic [CH_W-1:0]          res_ch;
    logic [LFSR_W-1:0]        res_offset;
    logic                     res_found;
    logic                     res_timeout;

    offset_finder_arbiter #(
        .NUM_CH          (NUM_CH),
        .CH_W            (CH_W),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clk_96MHz         (clk_96MHz),
        .reset             (reset),
        .req               (req),
        .req_polynomial    (req_polynomial),
        .req_data          (req_data),
        .finder_polynomial (finder_polynomial),
        .finder_data       (finder_data),
        .finder_enable     (finder_enable),
        .finder_offset     (finder_offset),
        .finder_ready      (finder_ready),
        .busy              (busy),
        .res_valid         (res_valid),
        .res_ch            (res_ch),
        .res_offset        (res_offset),
        .res_found         (res_found),
        .res_timeout       (res_timeout)
    );

    always #5 clk_96MHz = ~clk_96MHz;

    int cyc = 0;
    always @(posedge clk_96MHz) cyc <= cyc + 1;

    // Behavioural finder: leaves IDLE on enable, reports data^key after latency,
    // and goes back to IDLE only once enable is low.
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} model_state_t;
    model_state_t    mstate        = M_IDLE;
    int              mcnt          = 0;
    logic [16:0]     moff          = '0;
    int              model_latency = 10;
    logic [16:0]     model_key     = '0;
    logic            model_hang    = 1'b0;

    always @(posedge clk_96MHz) begin
        case (mstate)
            M_IDLE: if (finder_enable) begin
                mstate       <= M_RUN;
                finder_ready <= 1'b0;
                mcnt         <= model_latency;
                moff         <= finder_data ^ model_key;
            end
            M_RUN: if (!model_hang) begin
                if (mcnt <= 1) begin
                    finder_ready  <= 1'b1;
                    finder_offset <= moff;
                    mstate        <= M_DONE;
                end else begin
                    mcnt <= mcnt - 1;
                end
            end
            M_DONE: if (!finder_enable) mstate <= M_IDLE;
            default: mstate <= M_IDLE;
        endcase
    end

    typedef struct {
        logic [16:0] poly;
        logic [16:0] data;
    } grant_t;

    typedef struct {
        logic [1:0]  ch;
        logic [16:0] offset;
        logic        found;
        logic        timeout;
    } result_t;

    typedef struct {
        int          ch;
        logic [16:0] poly;
        logic [16:0] data;
        logic [16:0] key;
        int          latency;
        logic [16:0] exp_offset;
        logic        exp_found;
    } vec_t;

    grant_t      grant_q[$];
    result_t     result_q[$];
    logic [16:0] poly_of[NUM_CH];
    logic [16:0] data_of[NUM_CH];

    int compared   = 0;
    int mismatched = 0;
    int n_valid    = 0;
    int n_rise     = 0;
    int last_rise_cyc  = 0;
    int last_valid_cyc = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int c, input logic [16:0] poly, input logic [16:0] data);
        poly_of[c] = poly;
        data_of[c] = data;
        req_polynomial[17*c +: 17] = poly;
        req_data[17*c +: 17]       = data;
    endtask

    task automatic expectGrant(input int c);
        grant_q.push_back('{poly: poly_of[c], data: data_of[c]});
    endtask

    task automatic expectResult(input int c, input logic [16:0] off, input logic found, input logic tmo);
        result_q.push_back('{ch: 2'(c), offset: off, found: found, timeout: tmo});
    endtask

    task automatic tick();
        @(negedge clk_96MHz);
        #1;
    endtask

    task automatic waitResult(input int budget, input string name);
        int start = n_valid;
        int k = 0;
        while (n_valid == start && k < budget) begin
            tick();
            k++;
        end
        checkOutput(name, n_valid - start, 1);
    endtask

    task automatic waitRise(input int budget, input string name);
        int start = n_rise;
        int k = 0;
        while (n_rise == start && k < budget) begin
            tick();
            k++;
        end
        checkOutput(name, n_rise - start, 1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_enable"},  finder_enable, 0);
        checkOutput({tag, "_poly"},    finder_polynomial, 0);
        checkOutput({tag, "_data"},    finder_data, 0);
        checkOutput({tag, "_valid"},   res_valid, 0);
        checkOutput({tag, "_ch"},      res_ch, 0);
        checkOutput({tag, "_offset"},  res_offset, 0);
        checkOutput({tag, "_found"},   res_found, 0);
        checkOutput({tag, "_timeout"}, res_timeout, 0);
        checkOutput({tag, "_busy"},    busy, 1);
    endtask

    // Scoreboard monitor; the finder is idle for RELEASE x2 plus ARB, so
    // every enable rise is preceded by at least 3 low cycles.
    initial begin
        logic    prev_en = 1'b0;
        int      low_run = 0;
        grant_t  g;
        result_t r;
        forever begin
            @(negedge clk_96MHz);
            if (finder_enable && !prev_en) begin
                n_rise++;
                last_rise_cyc = cyc;
                checkOutput("enable_low_gap", 32'(low_run >= 3), 1);
                checkOutput("grant_expected", 32'(grant_q.size() > 0), 1);
                if (grant_q.size() > 0) begin
                    g = grant_q.pop_front();
                    checkOutput("grant_poly", finder_polynomial, g.poly);
                    checkOutput("grant_data", finder_data, g.data);
                end
            end
            low_run = finder_enable ? 0 : low_run + 1;
            prev_en = finder_enable;
            if (res_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
                checkOutput("result_expected", 32'(result_q.size() > 0), 1);
                if (result_q.size() > 0) begin
                    r = result_q.pop_front();
                    checkOutput("res_ch",      res_ch, r.ch);
                    checkOutput("res_offset",  res_offset, r.offset);
                    checkOutput("res_found",   res_found, r.found);
                    checkOutput("res_timeout", res_timeout, r.timeout);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish before 500000 ns");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        vec_t vecs[5];
        int   viol;
        int   k;
        int   ready_cyc;
        int   rr_order[5];

        vecs[0] = '{ch: 0, poly: 17'h1d258, data: 17'd1234,  key: 17'h00000, latency: 50, exp_offset: 17'd1234,  exp_found: 1'b1};
        vecs[1] = '{ch: 1, poly: 17'h12345, data: 17'h00000, key: 17'h00000, latency: 7,  exp_offset: 17'h00000, exp_found: 1'b0};
        vecs[2] = '{ch: 2, poly: 17'h0abcd, data: 17'h1ffff, key: 17'h0000f, latency: 3,  exp_offset: 17'h1fff0, exp_found: 1'b1};
        vecs[3] = '{ch: 3, poly: 17'h10001, data: 17'h00001, key: 17'h00001, latency: 1,  exp_offset: 17'h00000, exp_found: 1'b0};
        vecs[4] = '{ch: 1, poly: 17'h1aaaa, data: 17'h15555, key: 17'h0ffff, latency: 20, exp_offset: 17'h1aaaa, exp_found: 1'b1};
        rr_order = '{0, 1, 2, 3, 0};

        reset          = 1'b1;
        req            = '0;
        req_polynomial = '0;
        req_data       = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            poly_of[c] = '0;
            data_of[c] = '0;
        end
        repeat (3) tick();
        checkResetValues("por");
        reset = 1'b0;
        repeat (4) tick();
        checkOutput("busy_after_sync", busy, 0);

        // Single searches from the vector table.
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].ch, vecs[v].poly, vecs[v].data);
            model_key     = vecs[v].key;
            model_latency = vecs[v].latency;
            expectGrant(vecs[v].ch);
            expectResult(vecs[v].ch, vecs[v].exp_offset, vecs[v].exp_found, 1'b0);
            req[vecs[v].ch] = 1'b1;
            waitResult(300, "vec_result");
            req[vecs[v].ch] = 1'b0;
            repeat (3) tick();
        end

        // Reset while the finder is busy; the retry waits for two ready cycles.
        applyStimulus(3, 17'h1c0de, 17'h00abc);
        model_key     = '0;
        model_latency = 40;
        expectGrant(3);
        req[3] = 1'b1;
        waitRise(50, "rst_grant");
        repeat (10) tick();
        reset = 1'b1;
        tick();
        checkResetValues("mid_find");
        reset = 1'b0;
        expectGrant(3);
        expectResult(3, 17'h00abc, 1'b1, 1'b0);
        viol = 0;
        k    = 0;
        while (!finder_ready && k < 200) begin
            if (finder_enable || res_valid) viol++;
            tick();
            k++;
        end
        ready_cyc = cyc;
        checkOutput("rst_ready_back", finder_ready, 1);
        checkOutput("rst_quiet", viol, 0);
        waitResult(200, "rst_result");
        checkOutput("rst_resync_gap", last_rise_cyc - ready_cyc, 3);
        req[3] = 1'b0;
        repeat (3) tick();

        // Round robin with all four channels held; pointer is 0 here.
        model_latency = 10;
        model_key     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            applyStimulus(c, 17'h08000 + 17'(c * 17'h111), 17'h00400 + 17'(c * 3 + 1));
        end
        for (int i = 0; i < 5; i++) begin
            expectGrant(rr_order[i]);
            expectResult(rr_order[i], data_of[rr_order[i]], 1'b1, 1'b0);
        end
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            waitResult(100, "rr_result");
        end
        req = '0;
        repeat (3) tick();

        // Late arrival: ch2 granted from pointer 1, ch1 joins mid-search.
        applyStimulus(2, 17'h13579, 17'h02468);
        applyStimulus(1, 17'h0eca8, 17'h00777);
        expectGrant(2);
        expectResult(2, 17'h02468, 1'b1, 1'b0);
        expectGrant(1);
        expectResult(1, 17'h00777, 1'b1, 1'b0);
        req = 4'b0100;
        waitRise(20, "late_grant");
        repeat (3) tick();
        req[1] = 1'b1;
        waitResult(100, "late_ch2");
        req[2] = 1'b0;
        checkOutput("late_hold_r1", finder_data, 17'h02468);
        tick();
        checkOutput("late_hold_r2", finder_data, 17'h02468);
        waitResult(100, "late_ch1");
        req[1] = 1'b0;
        repeat (3) tick();

        // Watchdog abort on a hung finder, then a clean retry after resync.
        applyStimulus(0, 17'h1d258, 17'h00321);
        model_hang    = 1'b1;
        model_latency = 5;
        model_key     = '0;
        expectGrant(0);
        expectResult(0, 17'h00000, 1'b0, 1'b1);
        req[0] = 1'b1;
        waitResult(150, "wd_abort");
        checkOutput("wd_latency", last_valid_cyc - last_rise_cyc, WD);
        expectGrant(0);
        expectResult(0, 17'h00321, 1'b1, 1'b0);
        viol = 0;
        repeat (20) begin
            if (finder_enable) viol++;
            tick();
        end
        model_hang = 1'b0;
        k = 0;
        while (!finder_ready && k < 50) begin
            if (finder_enable) viol++;
            tick();
            k++;
        end
        ready_cyc = cyc;
        checkOutput("wd_quiet", viol, 0);
        waitResult(100, "wd_retry");
        checkOutput("wd_resync_gap", last_rise_cyc - ready_cyc, 3);
        req[0] = 1'b0;
        repeat (5) tick();

        checkOutput("queues_drained", grant_q.size() + result_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
